// File: rtl/frame_column_loader.sv
// Configuration-frame loader for a column of NumRows stacked subtiles: decodes framed
// commands, fills one FrameData word per row, then pulses the addressed FrameStrobe line.

module frame_row_reg #(
  parameter int W = 32
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) data_q <= '0;
    else         data_q <= data_d;
  end

  assign q = data_q;
endmodule

module frame_column_loader #(
  parameter int NumRows         = 2,
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int StrobeCycles    = 2
) (
  input  logic                                 UserCLK,
  input  logic                                 resetn,
  input  logic [FrameBitsPerRow-1:0]           cfg_data,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic                                 err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 err,
  output logic [15:0]                          frame_count
);
  localparam int FBPR = FrameBitsPerRow;
  localparam int RCW  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int SCW  = $clog2(StrobeCycles + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STROBE, SKIP} state_e;

  state_e                       state_q, state_d;
  logic [RCW-1:0]               row_q, row_d;
  logic [7:0]                   idx_q, idx_d;
  logic [SCW-1:0]               scnt_q, scnt_d;
  logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
  logic                         err_q, err_d;
  logic [15:0]                  frame_count_q, frame_count_d;

  logic                         acc, is_sync, in_range, last_row;
  logic [NumRows-1:0]           row_we;
  logic [NumRows-1:0][FBPR-1:0] row_data;

  assign cfg_ready = (state_q != STROBE);
  assign acc       = cfg_valid && cfg_ready;
  assign is_sync   = (cfg_data[FBPR-1 -: 8] == 8'hFA);
  assign in_range  = ({24'd0, cfg_data[7:0]} < 32'(MaxFramesPerCol));
  assign last_row  = (row_q == RCW'(NumRows - 1));

  always_comb begin
    for (int r = 0; r < NumRows; r++)
      row_we[r] = acc && (state_q == LOAD) && (row_q == RCW'(r));
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    idx_d         = idx_q;
    scnt_d        = scnt_q;
    frame_count_d = frame_count_q;
    // set has priority over a simultaneous clear
    err_d         = err_q & ~err_clr;
    case (state_q)
      IDLE: if (acc && is_sync) begin
        row_d = '0;
        if (in_range) begin
          idx_d   = cfg_data[7:0];
          state_d = LOAD;
        end else begin
          err_d   = 1'b1;
          state_d = SKIP;
        end
      end
      LOAD: if (acc) begin
        if (last_row) begin
          row_d         = '0;
          scnt_d        = SCW'(StrobeCycles);
          state_d       = STROBE;
          frame_count_d = (frame_count_q == 16'hFFFF) ? frame_count_q : frame_count_q + 16'd1;
        end else begin
          row_d = row_q + RCW'(1);
        end
      end
      STROBE: begin
        if (scnt_q == SCW'(1)) state_d = IDLE;
        else                   scnt_d  = scnt_q - SCW'(1);
      end
      SKIP: if (acc) begin
        if (last_row) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = row_q + RCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // strobe is registered off the next state so it rises together with STROBE
  always_comb begin
    strobe_d = '0;
    if (state_d == STROBE)
      for (int i = 0; i < MaxFramesPerCol; i++)
        strobe_d[i] = (idx_q == 8'(i));
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      row_q         <= '0;
      idx_q         <= '0;
      scnt_q        <= '0;
      strobe_q      <= '0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      idx_q         <= idx_d;
      scnt_q        <= scnt_d;
      strobe_q      <= strobe_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  for (genvar r = 0; r < NumRows; r++) begin : g_row
    frame_row_reg #(.W(FBPR)) u_row (
      .gclk   (UserCLK),
      .grst_n (resetn),
      .we     (row_we[r]),
      .d      (cfg_data),
      .q      (row_data[r])
    );
  end

  assign FrameData   = row_data;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_frame_column_loader.sv
// Scoreboard bench for frame_column_loader: expected strobes/row data are queued as
// commands are driven and checked by a monitor when the strobe appears.

module tb_frame_column_loader;
  localparam int NR = 2, FW = 32, MF = 20, SC = 2;

  logic                UserCLK = 1'b0;
  logic                resetn = 1'b0;
  logic [FW-1:0]       cfg_data = '0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic                err_clr = 1'b0;
  logic [NR*FW-1:0]    FrameData;
  logic [MF-1:0]       FrameStrobe;
  logic                busy, err;
  logic [15:0]         frame_count;

  frame_column_loader #(.NumRows(NR), .FrameBitsPerRow(FW), .MaxFramesPerCol(MF), .StrobeCycles(SC)) dut (
    .UserCLK(UserCLK), .resetn(resetn), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .err_clr(err_clr), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .err(err), .frame_count(frame_count)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct packed {
    logic [MF-1:0]    strobe;
    logic [NR*FW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0, n_pass = 0;
  logic [FW-1:0] exp_rows [NR];
  logic [15:0]   exp_fc;
  logic [MF-1:0] prev_strobe = '0;
  logic [NR*FW-1:0] run_data;
  int            run_len = 0;

  function automatic logic [NR*FW-1:0] rows_flat();
    return {exp_rows[1], exp_rows[0]};
  endfunction

  // Scoreboard monitor: pops an expectation on each strobe rising, checks pulse shape
  always @(negedge UserCLK) begin
    if (resetn) begin
      n_checks++;
      if (cfg_ready !== (FrameStrobe == '0))
        $display("FAIL ready_vs_strobe: ready=%b strobe=%h", cfg_ready, FrameStrobe);
      else n_pass++;
      n_checks++;
      if ($countones(FrameStrobe) > 1)
        $display("FAIL strobe_onehot: got %h", FrameStrobe);
      else n_pass++;
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_strobe: got %h want none", FrameStrobe);
        end else begin
          mon_e = sb.pop_front();
          if (FrameStrobe !== mon_e.strobe)
            $display("FAIL sb_strobe: got %h want %h", FrameStrobe, mon_e.strobe);
          else n_pass++;
          n_checks++;
          if (FrameData !== mon_e.data)
            $display("FAIL sb_framedata: got %h want %h", FrameData, mon_e.data);
          else n_pass++;
        end
        run_len  = 1;
        run_data = FrameData;
      end else if (FrameStrobe != '0) begin
        run_len++;
        n_checks++;
        if (FrameStrobe !== prev_strobe || FrameData !== run_data)
          $display("FAIL strobe_stable: got %h/%h want %h/%h", FrameStrobe, FrameData, prev_strobe, run_data);
        else n_pass++;
      end else if (prev_strobe != '0) begin
        n_checks++;
        if (run_len != SC) $display("FAIL strobe_len: got %0d want %0d", run_len, SC);
        else n_pass++;
      end
      prev_strobe = FrameStrobe;
    end else begin
      prev_strobe = '0;
    end
  end

  task automatic tick();
    @(posedge UserCLK); #1;
  endtask

  task automatic send(input logic [FW-1:0] w);
    int n = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    if (!cfg_ready) begin
      n_checks++;
      $display("FAIL send_timeout: ready=%b want 1", cfg_ready);
    end
    @(posedge UserCLK); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] idx, input logic [FW-1:0] d0, input logic [FW-1:0] d1);
    exp_t e;
    if (idx < MF) begin
      exp_rows[0] = d0;
      exp_rows[1] = d1;
      e.strobe = MF'(1) << idx;
      e.data   = rows_flat();
      sb.push_back(e);
      if (exp_fc != 16'hFFFF) exp_fc++;
    end
    send({8'hFA, 16'h0, idx});
    send(d0);
    send(d1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge UserCLK);
    #1;
    n_checks++;
    if ({FrameData, FrameStrobe, err, frame_count, busy} !== '0)
      $display("FAIL reset_state: got %h/%h/%b/%h/%b want zeros", FrameData, FrameStrobe, err, frame_count, busy);
    else n_pass++;
    resetn = 1'b1;
    exp_rows[0] = '0; exp_rows[1] = '0; exp_fc = '0;
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: ready=%b busy=%b want 1/0", cfg_ready, busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    cmd(8'd5, 32'h11111111, 32'h22222222);
    n_checks++;
    if (FrameStrobe !== 20'h00020 || cfg_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL basic_strobe1: got %h/%b/%b want 00020/0/1", FrameStrobe, cfg_ready, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (FrameStrobe !== 20'h00020 || cfg_ready !== 1'b0)
      $display("FAIL basic_strobe2: got %h/%b want 00020/0", FrameStrobe, cfg_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (FrameStrobe !== '0 || cfg_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd1)
      $display("FAIL basic_after: got %h/%b/%b/%h want 0/1/0/0001", FrameStrobe, cfg_ready, busy, frame_count);
    else n_pass++;
    n_checks++;
    if (FrameData !== 64'h22222222_11111111)
      $display("FAIL basic_data: got %h want 2222222211111111", FrameData);
    else n_pass++;
  endtask

  task automatic test_padding_stall();
    exp_t e;
    send(32'h00000000);
    send(32'h12345678);
    tick();
    n_checks++;
    if (FrameData !== rows_flat() || busy !== 1'b0 || frame_count !== exp_fc)
      $display("FAIL padding: got %h/%b/%h want %h/0/%h", FrameData, busy, frame_count, rows_flat(), exp_fc);
    else n_pass++;
    exp_rows[0] = 32'hA1B2C3D4;
    exp_rows[1] = 32'h0F0E0D0C;
    e.strobe = MF'(1) << 19;
    e.data   = rows_flat();
    sb.push_back(e);
    exp_fc++;
    send(32'hFA000013);
    send(exp_rows[0]);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (FrameStrobe !== '0 || busy !== 1'b1)
        $display("FAIL stall_wait: got %h/%b want 0/1", FrameStrobe, busy);
      else n_pass++;
    end
    send(exp_rows[1]);
    wait_idle();
    n_checks++;
    if (frame_count !== exp_fc) $display("FAIL stall_count: got %h want %h", frame_count, exp_fc);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    send(32'hFA000014);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b1) $display("FAIL oor_err: got %b/%b want 1/1", err, busy);
    else n_pass++;
    send(32'h33333333);
    send(32'h44444444);
    wait_idle();
    n_checks++;
    if (FrameData !== rows_flat() || frame_count !== exp_fc || err !== 1'b1)
      $display("FAIL oor_skip: got %h/%h/%b want %h/%h/1", FrameData, frame_count, err, rows_flat(), exp_fc);
    else n_pass++;
    cmd(8'd0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    wait_idle();
    n_checks++;
    if (err !== 1'b1 || FrameData !== rows_flat())
      $display("FAIL oor_follow: got %b/%h want 1/%h", err, FrameData, rows_flat());
    else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_clr: got %b want 0", err);
    else n_pass++;
    err_clr = 1'b1;
    send(32'hFA0000FF);
    err_clr = 1'b0;
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_set_wins: got %b want 1", err);
    else n_pass++;
    send(32'h55555555);
    send(32'h66666666);
    wait_idle();
    n_checks++;
    if (FrameData !== rows_flat()) $display("FAIL oor_skip2: got %h want %h", FrameData, rows_flat());
    else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_sync_in_data();
    cmd(8'd1, 32'hFA000003, 32'hABCDEF01);
    wait_idle();
    n_checks++;
    if (FrameData !== 64'hABCDEF01_FA000003)
      $display("FAIL sync_in_data: got %h want ABCDEF01FA000003", FrameData);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    send(32'hFA000002);
    send(32'hCAFEF00D);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (FrameData !== '0 || FrameStrobe !== '0 || busy !== 1'b0)
      $display("FAIL rst_mid_load: got %h/%h/%b want 0/0/0", FrameData, FrameStrobe, busy);
    else n_pass++;
    exp_rows[0] = '0; exp_rows[1] = '0; exp_fc = '0;
    @(negedge UserCLK);
    #2 resetn = 1'b1;
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || FrameData !== '0)
      $display("FAIL rst_mid_release: got %b/%b/%h want 1/0/0", cfg_ready, busy, FrameData);
    else n_pass++;
    cmd(8'd3, 32'h01020304, 32'h05060708);
    @(negedge UserCLK);
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (FrameStrobe !== '0 || FrameData !== '0 || frame_count !== 16'd0)
      $display("FAIL rst_mid_strobe: got %h/%h/%h want 0/0/0", FrameStrobe, FrameData, frame_count);
    else n_pass++;
    exp_rows[0] = '0; exp_rows[1] = '0; exp_fc = '0;
    @(negedge UserCLK);
    #2 resetn = 1'b1;
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_strobe_release: got %b/%b want 1/0", cfg_ready, busy);
    else n_pass++;
  endtask

  task automatic test_saturation();
    force dut.frame_count_q = 16'hFFFE;
    tick();
    release dut.frame_count_q;
    exp_fc = 16'hFFFE;
    n_checks++;
    if (frame_count !== 16'hFFFE) $display("FAIL sat_preload: got %h want FFFE", frame_count);
    else n_pass++;
    cmd(8'd7, 32'h77777777, 32'h88888888);
    wait_idle();
    n_checks++;
    if (frame_count !== exp_fc) $display("FAIL sat_reach: got %h want %h", frame_count, exp_fc);
    else n_pass++;
    cmd(8'd8, 32'h99999999, 32'hAAAAAAAA);
    wait_idle();
    n_checks++;
    if (frame_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want FFFF", frame_count);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_padding_stall();
    test_out_of_range();
    test_sync_in_data();
    test_reset_mid();
    test_saturation();
    repeat (3) tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
